// File: rtl/fcpu_uart_if.sv
// fcpu_uart byte-stream bundle between the fcpu core and the UART bridge.
// master = core side, slave = bridge side.
interface fcpu_uart_if;
  logic [7:0] io_o_data;
  logic       io_o_valid;
  logic       io_o_ready;
  logic [7:0] io_i_data;
  logic       io_i_valid;
  logic       io_i_ready;

  modport master (
    output io_o_data,
    output io_o_valid,
    output io_i_ready,
    input  io_o_ready,
    input  io_i_data,
    input  io_i_valid
  );

  modport slave (
    input  io_o_data,
    input  io_o_valid,
    input  io_i_ready,
    output io_o_ready,
    output io_i_data,
    output io_i_valid
  );
endinterface

// File: rtl/fcpu_uart.sv
// fcpu_uart: 8N1 LSB-first UART bridge for the fcpu byte streams.
// Independent TX and RX FSMs, all outputs registered.
module fcpu_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        nrst,
  fcpu_uart_if.slave  io,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        rx_overrun,
  output logic        rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_st_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_st_t;

  tx_st_t          r_tx_st;
  logic [CW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_tx_rdy;
  logic            r_txd;

  rx_st_t          r_rx_st;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_vld;
  logic            r_rx_s1;
  logic            r_rx_s2;
  logic            r_rx_prev;
  logic            r_rx_ovr;
  logic            r_rx_ferr;

  logic            w_tx_go;
  logic            w_rxs;
  logic            w_rx_fall;

  assign w_tx_go   = io.io_o_valid & r_tx_rdy;
  assign w_rxs     = r_rx_s2;
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;

  assign io.io_o_ready = r_tx_rdy;
  assign io.io_i_data  = r_rx_data;
  assign io.io_i_valid = r_rx_vld;
  assign uart_txd      = r_txd;
  assign rx_overrun    = r_rx_ovr;
  assign rx_frame_err  = r_rx_ferr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_st    <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_rdy   <= 1'b1;
      r_txd      <= 1'b1;
    end else begin
      unique case (r_tx_st)
        TX_IDLE: begin
          if (w_tx_go) begin
            r_tx_shift <= io.io_o_data;
            r_tx_cnt   <= '0;
            r_tx_rdy   <= 1'b0;
            r_txd      <= 1'b0;
            r_tx_st    <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_st    <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_tx_st <= TX_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == LAST) begin
            r_tx_cnt <= '0;
            r_tx_rdy <= 1'b1;
            r_tx_st  <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_vld   <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1   <= uart_rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_ovr  <= 1'b0;
      r_rx_ferr <= 1'b0;
      if (r_rx_vld && io.io_i_ready) r_rx_vld <= 1'b0;
      unique case (r_rx_st)
        // prev tracks rxs, so after a low stop bit no edge fires until rxs rises
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt <= '0;
            r_rx_st  <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_st  <= w_rxs ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxs, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == LAST) begin
            r_rx_cnt <= '0;
            r_rx_st  <= RX_IDLE;
            if (!w_rxs) begin
              r_rx_ferr <= 1'b1;
            end else if (!r_rx_vld || io.io_i_ready) begin
              r_rx_data <= r_rx_shift;
              r_rx_vld  <= 1'b1;
            end else begin
              r_rx_ovr <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcpu_uart.sv
// Self-checking bench for fcpu_uart at CLKS_PER_BIT=8.
`timescale 1ns/1ps
module tb_fcpu_uart;

  localparam int CPB = 8;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk;
  logic nrst;
  logic uart_txd;
  logic uart_rxd;
  logic rx_overrun;
  logic rx_frame_err;

  fcpu_uart_if u_if ();

  fcpu_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .io           (u_if),
    .uart_txd     (uart_txd),
    .uart_rxd     (uart_rxd),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int ovr_cyc = 0;
  int vrise_cyc = 0;
  int rx_p = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_frame_err) ferr_cnt++;
    if (rx_overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (u_if.io_i_valid && !prev_v) vrise_cyc = cyc;
    prev_v = u_if.io_i_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_ready();
    int n;
    n = 0;
    while (!u_if.io_o_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("tx_ready_wait", int'(u_if.io_o_ready), 1);
  endtask

  // expected line level for cycle offset i after the handshake
  function automatic logic tx_exp(input logic [7:0] b, input int i);
    int k;
    k = (i - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[3'(k - 1)];
  endfunction

  task automatic tx_frame(input logic [7:0] b);
    int werr;
    int rerr;
    wait_tx_ready();
    u_if.io_o_valid = 1'b1;
    u_if.io_o_data  = b;
    tick();
    u_if.io_o_valid = 1'b0;
    u_if.io_o_data  = ~b;
    werr = 0;
    rerr = 0;
    for (int i = 1; i <= 10 * CPB; i++) begin
      if (uart_txd !== tx_exp(b, i)) werr++;
      if (u_if.io_o_ready !== 1'b0) rerr++;
      tick();
    end
    chk("tx_wave", werr, 0);
    chk("tx_busy", rerr, 0);
    chk("tx_ready_rise", int'(u_if.io_o_ready), 1);
    chk("tx_idle_high", int'(uart_txd), 1);
  endtask

  task automatic rx_drive(input logic [7:0] b, input logic stop,
                          input real bns);
    rx_p = cyc;
    uart_rxd = 1'b0;
    #(bns);
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      #(bns);
    end
    uart_rxd = stop;
    #(bns);
    uart_rxd = 1'b1;
  endtask

  task automatic consume();
    u_if.io_i_ready = 1'b1;
    tick();
    u_if.io_i_ready = 1'b0;
    chk("rx_valid_clear", int'(u_if.io_i_valid), 0);
  endtask

  typedef struct {
    logic [7:0] tx_b;
    logic [7:0] rx_b;
    logic       stop;
    logic       exp_v;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] q [$];

  initial begin
    int f0, o0, p1, p2, hs, t1, t2, bad, n;
    logic b1, b2, b3;
    logic [7:0] rb, tb, eb;
    real bns;

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h81, 8'h55, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 8'hC3, 1'b0, 1'b0, 1'b1};

    nrst = 1'b0;
    uart_rxd = 1'b1;
    u_if.io_o_valid = 1'b0;
    u_if.io_o_data  = 8'h00;
    u_if.io_i_ready = 1'b0;
    repeat (3) tick();
    chk("rst_txd", int'(uart_txd), 1);
    chk("rst_o_ready", int'(u_if.io_o_ready), 1);
    chk("rst_i_valid", int'(u_if.io_i_valid), 0);
    chk("rst_i_data", int'(u_if.io_i_data), 0);
    chk("rst_overrun", int'(rx_overrun), 0);
    chk("rst_frame_err", int'(rx_frame_err), 0);
    nrst = 1'b1;
    repeat (2) tick();

    // RX latency and hold until consumed
    rx_drive(8'h3C, 1'b1, 80.0);
    repeat (2) tick();
    chk("rx_latency", vrise_cyc - rx_p, LAT);
    chk("rx_data", int'(u_if.io_i_data), 8'h3C);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (u_if.io_i_valid !== 1'b1 || u_if.io_i_data !== 8'h3C) bad++;
      tick();
    end
    chk("rx_hold", bad, 0);
    consume();

    for (int i = 0; i < 5; i++) begin
      f0 = ferr_cnt;
      fork
        tx_frame(vecs[i].tx_b);
        rx_drive(vecs[i].rx_b, vecs[i].stop, 80.0);
      join
      repeat (3) tick();
      chk("vec_valid", int'(u_if.io_i_valid), int'(vecs[i].exp_v));
      if (vecs[i].exp_v)
        chk("vec_data", int'(u_if.io_i_data), int'(vecs[i].rx_b));
      chk("vec_frame_err", ferr_cnt - f0, int'(vecs[i].exp_fe));
      if (u_if.io_i_valid) consume();
    end

    // overrun: second frame dropped
    o0 = ovr_cnt;
    rx_drive(8'h11, 1'b1, 80.0);
    p1 = rx_p;
    rx_drive(8'h22, 1'b1, 80.0);
    p2 = rx_p;
    repeat (4) tick();
    chk("ovr_first_rise", vrise_cyc - p1, LAT);
    chk("ovr_data", int'(u_if.io_i_data), 8'h11);
    chk("ovr_valid", int'(u_if.io_i_valid), 1);
    chk("ovr_count", ovr_cnt - o0, 1);
    chk("ovr_cycle", ovr_cyc - p2, LAT);
    consume();

    // two-cycle glitch is a false start
    f0 = ferr_cnt;
    uart_rxd = 1'b0;
    repeat (2) tick();
    uart_rxd = 1'b1;
    repeat (120) tick();
    chk("glitch_valid", int'(u_if.io_i_valid), 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);

    // TX back-to-back with valid held high
    wait_tx_ready();
    u_if.io_o_valid = 1'b1;
    u_if.io_o_data  = 8'h00;
    hs = 0;
    t1 = 0;
    t2 = 0;
    b1 = 1'b1;
    b2 = 1'b0;
    b3 = 1'b1;
    n = 0;
    while (hs < 2 && n < 400) begin
      if (u_if.io_o_ready) begin
        hs++;
        if (hs == 1) t1 = cyc;
        else begin
          t2 = cyc;
          b2 = uart_txd;
        end
      end
      tick();
      n++;
      if (hs == 1 && cyc == t1 + 1) begin
        u_if.io_o_data = 8'hFF;
        b1 = uart_txd;
      end
      if (hs == 2) begin
        u_if.io_o_valid = 1'b0;
        b3 = uart_txd;
      end
    end
    u_if.io_o_valid = 1'b0;
    chk("b2b_handshakes", hs, 2);
    chk("b2b_spacing", t2 - t1, 10 * CPB + 1);
    chk("b2b_first_start", int'(b1), 0);
    chk("b2b_idle_gap", int'(b2), 1);
    chk("b2b_second_start", int'(b3), 0);
    repeat (CPB + CPB / 2) tick();
    chk("b2b_second_bit0", int'(uart_txd), 1);
    wait_tx_ready();

    // reset during TX data bit 3
    u_if.io_o_valid = 1'b1;
    u_if.io_o_data  = 8'hF0;
    tick();
    u_if.io_o_valid = 1'b0;
    repeat (4 * CPB + 2) tick();
    chk("rst_tx_pre", int'(uart_txd), 0);
    nrst = 1'b0;
    #1;
    chk("rst_tx_async", int'(uart_txd), 1);
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    chk("rst_tx_ready", int'(u_if.io_o_ready), 1);
    chk("rst_tx_txd", int'(uart_txd), 1);
    tx_frame(8'h81);

    // random bytes both ways, RX rate off by up to 3%
    for (int it = 0; it < 8; it++) begin
      rb = 8'($urandom);
      tb = 8'($urandom);
      bns = 80.0 * (0.97 + real'($urandom_range(0, 60)) / 1000.0);
      q.push_back(rb);
      fork
        tx_frame(tb);
        rx_drive(rb, 1'b1, bns);
      join
      n = 0;
      tick();
      while (!u_if.io_i_valid && n < 200) begin
        tick();
        n++;
      end
      chk("rand_rx_valid", int'(u_if.io_i_valid), 1);
      eb = q.pop_front();
      chk("rand_rx_data", int'(u_if.io_i_data), int'(eb));
      repeat ($urandom_range(0, 5)) tick();
      consume();
      repeat ($urandom_range(0, 20)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcpu_uart.md
# fcpu_uart

Serial bridge between the fcpu core's byte I/O streams and a UART pin pair. It sits in the fcpu top next to `core_inst`:
- It consumes the core's output stream (`io_o_*`) and serialises each byte onto `uart_txd`.
- It deserialises `uart_rxd` into the core's input stream (`io_i_*`).
- Frame format is fixed 8N1, LSB first. Both directions are independent and may be active simultaneously.

## Interface
- `CLKS_PER_BIT`, default 868, clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `io_o_data`  in  8  byte from core to transmit.
- `io_o_valid`  in  1  core offers `io_o_data`.
- `io_o_ready`  out  1  bridge accepts a byte this cycle.
- `io_i_data`  out  8  received byte to core.
- `io_i_valid`  out  1  `io_i_data` holds an unread byte.
- `io_i_ready`  in  1  core consumes `io_i_data` this cycle.
- `uart_txd`  out  1  serial out; idles high.
- `uart_rxd`  in  1  serial in; asynchronous to `clk`.
- `rx_overrun`  out  1  one-cycle pulse: a byte was dropped because the holding register was full.
- `rx_frame_err`  out  1  one-cycle pulse: the stop bit sampled low and the byte was discarded.

## Operation
- Reset values: `uart_txd`=1, `io_o_ready`=1, `io_i_valid`=0, `io_i_data`=0, `rx_overrun`=0, `rx_frame_err`=0. The RX synchroniser flops reset to 1.
- All outputs are registered. The bit counter width is `$clog2(CLKS_PER_BIT)`; the bit index is 3 bits.
- TX FSM states: IDLE → START → DATA(×8) → STOP → IDLE.
  - A handshake is `io_o_valid && io_o_ready`. It is possible only in IDLE, latches `io_o_data` into the shift register, and enters START.
  - `io_o_ready` is 1 only in IDLE.
  - START drives 0, DATA drives shift[0] then shifts right, STOP drives 1. Each state lasts exactly `CLKS_PER_BIT` cycles.
  - `io_o_data` changing after the handshake has no effect on the frame in flight.
- RX path: `uart_rxd` passes through a 2-flop synchroniser; all RX logic uses the synchronised value `rxs`.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge on `rxs` enters START.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division) and resample. If `rxs`=1 it is a false start: return to IDLE with no output.
  - DATA: sample at each `CLKS_PER_BIT` interval, 8 times, LSB first into the shift register.
  - STOP: sample once after a further `CLKS_PER_BIT` cycles.
    - If the stop bit is 0: pulse `rx_frame_err`, discard the byte, and go to IDLE. IDLE waits for `rxs`=1 before arming edge detection again.
    - If the stop bit is 1 and the holding register is empty (or emptied this same cycle by `io_i_ready`): load `io_i_data` and set `io_i_valid` on the next edge.
    - If the stop bit is 1 and the holding register is full with no `io_i_ready` this cycle: keep the old byte and pulse `rx_overrun`.
- `io_i_valid` stays high until a cycle with `io_i_ready`=1; it then clears on the next edge unless a new byte loads in that same cycle.
- `io_i_data` is stable while `io_i_valid`=1.
- Reset mid-frame (either direction): the frame is abandoned, `uart_txd` goes high immediately (asynchronously), and any pending RX byte is lost.

## Timing
- TX, handshake at cycle t:
  - `uart_txd` falls at t+1.
  - Start bit covers t+1 … t+CPB.
  - Data bit k covers t+1+(k+1)·CPB …
  - Stop bit ends at t+10·CPB.
  - `io_o_ready` rises at t+1+10·CPB.
  - Minimum frame-to-frame spacing is therefore 10·CPB+1 cycles: one idle-high cycle between frames.
- RX: sample points are at CPB/2 + n·CPB cycles after the falling edge of `rxs`. `rxs` lags the pin by 2 cycles.
- RX latency: `io_i_valid` rises 1 cycle after the stop-bit sample, i.e. 2 + CPB/2 + 9·CPB + 1 cycles after the pin's falling edge.
- A new RX start bit is accepted from the cycle after the stop-bit sample, which tolerates the sender's half-bit stop.
- Tolerance: ±4% baud mismatch must be received correctly.

## Test plan
- TX single byte, CPB=8: send 0xA5 at t → `uart_txd` = 0,1,0,1,0,0,1,0,1,1 (each held 8 cycles, starting t+1). `io_o_ready`=0 t+1…t+80, and 1 at t+81.
- TX back-to-back: `io_o_valid` held high with 0x00 then 0xFF → the second handshake occurs exactly at t+81, and exactly one idle-high cycle separates the frames.
- RX byte 0x3C driven at CPB=8 with `io_i_ready`=0 → `io_i_valid` rises 2+4+72+1=79 cycles after the start edge, `io_i_data`=0x3C, and both hold until `io_i_ready` pulses.
- RX overrun: two frames (0x11, 0x22) with `io_i_ready`=0 → `io_i_data` remains 0x11, and `rx_overrun` pulses once, at the second frame's stop sample.
- RX errors:
  - A 2-cycle low glitch is treated as a false start: no `io_i_valid`.
  - A frame with the stop bit low gives a `rx_frame_err` pulse and no `io_i_valid`. A following valid 0x55 is then received correctly.
- Reset mid-TX: assert `nrst`=0 during data bit 3 → `uart_txd`=1 immediately and `io_o_ready`=1 after release. The next byte 0x81 transmits correctly.
